bank_read_arbiter: RTL and testbench
====================================

BANK_READ_ARBITER -- requirements
Module: bank_read_arbiter

Interface
REQ-001 Parameter PORT_NUM, default 2, is the number of vector read ports.
REQ-002 Parameter ADDR_WIDTH, default 6, is the vreg address width.
REQ-003 Parameter ADDR_X_WIDTH, default 1, is the number of X bank-select bits at vreg_addr[ADDR_X_WIDTH-1:0].
REQ-004 Parameter ADDR_Y_WIDTH, default 4, is the bank row width at vreg_addr[ADDR_X_WIDTH +: ADDR_Y_WIDTH].
REQ-005 Parameter DATA_WIDTH, default 128, is the bank read data width.
REQ-006 Port clk, input, 1 bit, is the single clock; all state is on its rising edge.
REQ-007 Port rst, input, 1 bit, is the reset; asynchronous, active-high.
REQ-008 Port req_valid, input, [PORT_NUM], is the read request valid for each port.
REQ-009 Port req_addr, input, [PORT_NUM][ADDR_WIDTH], is the vreg address for each port.
REQ-010 Port req_ready, output, [PORT_NUM], signals request accepted (granted) this cycle.
REQ-011 Port bank_rd_en, output, [4], is the read enable for each bank.
REQ-012 Port bank_rd_addr, output, [4][ADDR_Y_WIDTH], is the row address for each bank.
REQ-013 Port bank_rd_data, input, [4][DATA_WIDTH], is bank data, valid the cycle after bank_rd_en.
REQ-014 Port rsp_valid, output, [PORT_NUM], is the read response valid.
REQ-015 Port rsp_data, output, [PORT_NUM][DATA_WIDTH], is the read response data.
REQ-016 Port rsp_ready, input, [PORT_NUM], signals the consumer accepts the response.

Function
REQ-017 Bank index SHALL be {req_addr[ADDR_WIDTH-1], req_addr[0]} (Y-half, X); row SHALL be req_addr[ADDR_X_WIDTH +: ADDR_Y_WIDTH].
REQ-018 Each bank SHALL grant at most one port per cycle; each port SHALL receive at most one grant per cycle.
REQ-019 A port SHALL be eligible iff req_valid=1, its hold buffer is empty, and NOT (in-flight=1 and rsp_ready=0).
REQ-020 Each bank SHALL pick, among eligible ports targeting it, the first at or after its rr_ptr, wrapping modulo PORT_NUM.
REQ-021 After a grant to port p, that bank's rr_ptr SHALL become (p+1) mod PORT_NUM; rr_ptr SHALL be unchanged for banks with no grant.
REQ-022 On a grant in cycle T: req_ready[p]=1, bank_rd_en[b]=1, and bank_rd_addr[b]=row, all combinational in T; bank_rd_addr SHALL be 0 when the bank is not enabled.
REQ-023 On a grant in cycle T, in-flight[p] SHALL be set with bank_q[p]=b at the edge ending T.
REQ-024 In cycle T+1, rsp_valid[p]=1 and rsp_data[p]=bank_rd_data[bank_q[p]] (latency 1).
REQ-025 If rsp_ready[p]=0 in T+1, the data SHALL be captured into hold[p]; rsp_valid[p] SHALL stay 1 with the held data until rsp_ready[p]=1.
REQ-026 A hold buffer SHALL take priority over in-flight data; a simultaneous hold and in-flight on one port is impossible by REQ-019 and SHALL be asserted against.
REQ-027 Back-to-back grants to a port SHALL be allowed when rsp_ready stays 1, giving 1 response per cycle per port.
REQ-028 Requests to distinct banks SHALL all be granted in the same cycle.
REQ-029 req_valid deasserted after a grant SHALL NOT cancel the in-flight response.

Reset
REQ-030 While rst=1: rr_ptr=0, in-flight=0, hold valid=0, hold data=0, rsp_valid=0, req_ready=0, bank_rd_en=0, bank_rd_addr=0, rsp_data=0.
REQ-031 Reset asserted mid-operation SHALL discard in-flight and held responses; no rsp_valid SHALL appear after reset release for pre-reset grants.

Verification
REQ-032 Port0 addr 0x03 and port1 addr 0x02, both valid, rsp_ready=1 -> cycle T: bank_rd_en=4'b0011, rows both 1; T+1: rsp_valid=2'b11 with the respective bank data.
REQ-033 Both ports to addr 0x05 (bank 1, row 2) for 4 cycles, rsp_ready=1 -> grants alternate p0,p1,p0,p1; exactly one req_ready per cycle.
REQ-034 Port0 granted, rsp_ready[0]=0 for 3 cycles -> rsp_valid[0] held 3 cycles with the T+1 data stable; req_ready[0]=0 throughout; grant resumes the cycle after acceptance.
REQ-035 Port0 streams addrs 0x00..0x07 with rsp_ready=1 -> 8 consecutive responses, each 1 cycle after its grant, in order.
REQ-036 rst pulsed in the cycle after a grant -> no rsp_valid after release; rr_ptr=0, so p0 wins the first subsequent conflict.

Source files
------------

// File: rtl/bank_read_arbiter_if.sv
// Request, bank and response signals of the vector-register bank read arbiter.
// The slave modport is the arbiter; the master modport is the requester/bank side.
interface bank_read_arbiter_if #(
   parameter int PORT_NUM     = 2,
   parameter int ADDR_WIDTH   = 6,
   parameter int ADDR_Y_WIDTH = 4,
   parameter int DATA_WIDTH   = 128
);
   logic [PORT_NUM-1:0]                  req_valid;
   logic [PORT_NUM-1:0][ADDR_WIDTH-1:0]  req_addr;
   logic [PORT_NUM-1:0]                  req_ready;
   logic [3:0]                           bank_rd_en;
   logic [3:0][ADDR_Y_WIDTH-1:0]         bank_rd_addr;
   logic [3:0][DATA_WIDTH-1:0]           bank_rd_data;
   logic [PORT_NUM-1:0]                  rsp_valid;
   logic [PORT_NUM-1:0][DATA_WIDTH-1:0]  rsp_data;
   logic [PORT_NUM-1:0]                  rsp_ready;

   modport slave (
      input  req_valid, req_addr, bank_rd_data, rsp_ready,
      output req_ready, bank_rd_en, bank_rd_addr, rsp_valid, rsp_data
   );

   modport master (
      output req_valid, req_addr, bank_rd_data, rsp_ready,
      input  req_ready, bank_rd_en, bank_rd_addr, rsp_valid, rsp_data
   );
endinterface

// File: rtl/bank_read_arbiter.sv
// Four-bank vreg read arbiter: per-bank round-robin grant, one-cycle read latency,
// and a one-entry hold buffer per port that parks data while the consumer stalls.
module bank_read_arbiter #(
   parameter int PORT_NUM     = 2,
   parameter int ADDR_WIDTH   = 6,
   parameter int ADDR_X_WIDTH = 1,
   parameter int ADDR_Y_WIDTH = 4,
   parameter int DATA_WIDTH   = 128
) (
   input logic                clk,
   input logic                rst,
   bank_read_arbiter_if.slave bus
);

   localparam int NUM_BANKS = 4;
   localparam int PTR_W     = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

   logic [NUM_BANKS-1:0][PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [PORT_NUM-1:0]                 inflight_q;
   logic [PORT_NUM-1:0][1:0]            bank_q;
   logic [PORT_NUM-1:0]                 hold_vld_q;
   logic [PORT_NUM-1:0][DATA_WIDTH-1:0] hold_data_q;

   logic [PORT_NUM-1:0][1:0]              req_bank;
   logic [PORT_NUM-1:0][ADDR_Y_WIDTH-1:0] req_row;
   logic [PORT_NUM-1:0]                   eligible;
   logic [PORT_NUM-1:0]                   grant;
   logic [NUM_BANKS-1:0]                  bank_en;
   logic [NUM_BANKS-1:0][ADDR_Y_WIDTH-1:0] bank_addr;

   // A port stalled on an unaccepted response must not issue another read.
   always_comb begin
      for (int p = 0; p < PORT_NUM; p++) begin
         req_bank[p] = {bus.req_addr[p][ADDR_WIDTH-1], bus.req_addr[p][0]};
         req_row[p]  = bus.req_addr[p][ADDR_X_WIDTH +: ADDR_Y_WIDTH];
         eligible[p] = !rst && bus.req_valid[p] && !hold_vld_q[p] &&
                       !(inflight_q[p] && !bus.rsp_ready[p]);
      end
   end

   // Each port targets exactly one bank, so per-bank arbitration alone
   // guarantees at most one grant per port.
   always_comb begin
      int                 sum;
      logic               found;
      logic [PTR_W-1:0]   idx;
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      sum       = 0;
      found     = 1'b0;
      idx       = '0;
      grant     = '0;
      bank_en   = '0;
      bank_addr = '0;
      rr_ptr_d  = rr_ptr_q;
      for (int b = 0; b < NUM_BANKS; b++) begin
         found = 1'b0;
         for (int i = 0; i < PORT_NUM; i++) begin
            sum = int'(rr_ptr_q[b]) + i;
            if (sum >= PORT_NUM) sum = sum - PORT_NUM;
            idx = PTR_W'(sum);
            if (!found && eligible[idx] && (req_bank[idx] == 2'(b))) begin
               found        = 1'b1;
               grant[idx]   = 1'b1;
               bank_en[b]   = 1'b1;
               bank_addr[b] = req_row[idx];
               rr_ptr_d[b]  = (sum == PORT_NUM - 1) ? '0 : PTR_W'(sum + 1);
            end
         end
      end
   end

   assign bus.req_ready    = grant;
   assign bus.bank_rd_en   = bank_en;
   assign bus.bank_rd_addr = bank_addr;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   // NOTE: the hold data is reset too, so rsp_data reads zero until real data arrives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q    <= '0;
         inflight_q  <= '0;
         bank_q      <= '0;
         hold_vld_q  <= '0;
         hold_data_q <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         inflight_q <= grant;
         for (int p = 0; p < PORT_NUM; p++) begin
            if (grant[p]) bank_q[p] <= req_bank[p];
            if (hold_vld_q[p]) begin
               if (bus.rsp_ready[p]) hold_vld_q[p] <= 1'b0;
            end else if (inflight_q[p] && !bus.rsp_ready[p]) begin
               hold_vld_q[p]  <= 1'b1;
               hold_data_q[p] <= bus.bank_rd_data[bank_q[p]];
            end
         end
      end
   end

   always_comb begin
      for (int p = 0; p < PORT_NUM; p++) begin
         bus.rsp_valid[p] = hold_vld_q[p] | inflight_q[p];
         if (hold_vld_q[p])      bus.rsp_data[p] = hold_data_q[p];
         else if (inflight_q[p]) bus.rsp_data[p] = bus.bank_rd_data[bank_q[p]];
         else                    bus.rsp_data[p] = '0;
      end
   end

   hold_inflight_excl_a : assert property (@(posedge clk) disable iff (rst)
      (hold_vld_q & inflight_q) == '0);

endmodule

// File: tb/tb_bank_read_arbiter.sv
// Directed bench for bank_read_arbiter: a vector table of single grants plus
// hand-written sequences for round-robin, stall/hold, streaming and reset.
module tb_bank_read_arbiter;

   localparam int PN = 2;
   localparam int AW = 6;
   localparam int YW = 4;
   localparam int DW = 128;
   localparam logic [DW-1:0] JUNK = {4{32'hDEAD_BEEF}};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bank_read_arbiter_if #(.PORT_NUM(PN), .ADDR_WIDTH(AW), .ADDR_Y_WIDTH(YW), .DATA_WIDTH(DW)) bus ();

   bank_read_arbiter #(
      .PORT_NUM(PN), .ADDR_WIDTH(AW), .ADDR_X_WIDTH(1), .ADDR_Y_WIDTH(YW), .DATA_WIDTH(DW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   function automatic logic [DW-1:0] bank_word(input logic [1:0] b, input logic [3:0] row);
      return {4{6'b101100, b, 4'h0, row, 16'hC3A5}};
   endfunction

   function automatic logic [1:0] bank_of(input logic [AW-1:0] a);
      return {a[AW-1], a[0]};
   endfunction

   function automatic logic [3:0] row_of(input logic [AW-1:0] a);
      return a[4:1];
   endfunction

   // Bank memory model: data one cycle after the enable, junk otherwise.
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         bus.bank_rd_data[b] <= bus.bank_rd_en[b] ? bank_word(2'(b), bus.bank_rd_addr[b]) : JUNK;
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req_valid = '0;
      bus.rsp_ready = 2'b11;
      next_cycle();
      rst = 1'b0;
      next_cycle();
   endtask

   typedef struct {
      logic [1:0]    valid;
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      logic [1:0]    exp_ready;
      logic [3:0]    exp_en;
      logic [15:0]   exp_addr;
   } vec_t;

   vec_t vecs [9];

   initial begin
      logic [1:0]    exp_r;
      logic [1:0]    exp_v;
      logic [AW-1:0] a;
      logic [AW-1:0] ap;

      vecs[0] = '{2'b11, 6'h03, 6'h02, 2'b11, 4'b0011, 16'h0011};
      vecs[1] = '{2'b11, 6'h05, 6'h05, 2'b10, 4'b0010, 16'h0020};
      vecs[2] = '{2'b11, 6'h05, 6'h05, 2'b01, 4'b0010, 16'h0020};
      vecs[3] = '{2'b01, 6'h20, 6'h00, 2'b01, 4'b0100, 16'h0000};
      vecs[4] = '{2'b11, 6'h21, 6'h3F, 2'b01, 4'b1000, 16'h0000};
      vecs[5] = '{2'b11, 6'h21, 6'h3F, 2'b10, 4'b1000, 16'hF000};
      vecs[6] = '{2'b10, 6'h00, 6'h1E, 2'b10, 4'b0001, 16'h000F};
      vecs[7] = '{2'b00, 6'h00, 6'h00, 2'b00, 4'b0000, 16'h0000};
      vecs[8] = '{2'b11, 6'h3E, 6'h23, 2'b11, 4'b1100, 16'h1F00};

      // Reset state with live requests present.
      bus.req_valid   = 2'b11;
      bus.req_addr[0] = 6'h03;
      bus.req_addr[1] = 6'h02;
      bus.rsp_ready   = 2'b11;
      @(negedge clk);
      @(negedge clk);
      check("rst_req_ready", DW'(bus.req_ready), '0);
      check("rst_bank_en", DW'(bus.bank_rd_en), '0);
      check("rst_bank_addr", DW'(bus.bank_rd_addr), '0);
      check("rst_rsp_valid", DW'(bus.rsp_valid), '0);
      check("rst_rsp_data0", bus.rsp_data[0], '0);
      check("rst_rsp_data1", bus.rsp_data[1], '0);
      next_cycle();
      rst = 1'b0;
      bus.req_valid = '0;
      next_cycle();

      // Vector table: grant cycle, then the response cycle.
      for (int v = 0; v < 9; v++) begin
         bus.req_valid   = vecs[v].valid;
         bus.req_addr[0] = vecs[v].a0;
         bus.req_addr[1] = vecs[v].a1;
         @(negedge clk);
         check($sformatf("v%0d_req_ready", v), DW'(bus.req_ready), DW'(vecs[v].exp_ready));
         check($sformatf("v%0d_bank_en", v), DW'(bus.bank_rd_en), DW'(vecs[v].exp_en));
         check($sformatf("v%0d_bank_addr", v), DW'(bus.bank_rd_addr), DW'(vecs[v].exp_addr));
         next_cycle();
         bus.req_valid = '0;
         @(negedge clk);
         check($sformatf("v%0d_rsp_valid", v), DW'(bus.rsp_valid), DW'(vecs[v].exp_ready));
         if (vecs[v].exp_ready[0])
            check($sformatf("v%0d_rsp_data0", v), bus.rsp_data[0],
                  bank_word(bank_of(vecs[v].a0), row_of(vecs[v].a0)));
         if (vecs[v].exp_ready[1])
            check($sformatf("v%0d_rsp_data1", v), bus.rsp_data[1],
                  bank_word(bank_of(vecs[v].a1), row_of(vecs[v].a1)));
         next_cycle();
      end

      // Round-robin on one contended bank.
      do_reset();
      bus.req_valid   = 2'b11;
      bus.req_addr[0] = 6'h05;
      bus.req_addr[1] = 6'h05;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         exp_r = (k % 2 == 0) ? 2'b01 : 2'b10;
         exp_v = (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10);
         check($sformatf("rr%0d_req_ready", k), DW'(bus.req_ready), DW'(exp_r));
         check($sformatf("rr%0d_rsp_valid", k), DW'(bus.rsp_valid), DW'(exp_v));
         if (k > 0)
            check($sformatf("rr%0d_rsp_data", k), bus.rsp_data[(k % 2 == 1) ? 0 : 1], bank_word(2'd1, 4'd2));
         next_cycle();
      end
      bus.req_valid = '0;
      @(negedge clk);
      check("rr_last_rsp_valid", DW'(bus.rsp_valid), DW'(2'b10));
      check("rr_last_rsp_data", bus.rsp_data[1], bank_word(2'd1, 4'd2));
      next_cycle();

      // Consumer stall on port 0: hold buffer keeps the response stable.
      do_reset();
      bus.req_valid   = 2'b01;
      bus.req_addr[0] = 6'h03;
      @(negedge clk);
      check("stall_first_grant", DW'(bus.req_ready[0]), DW'(1'b1));
      next_cycle();
      bus.rsp_ready = 2'b10;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("stall%0d_rsp_valid", k), DW'(bus.rsp_valid[0]), DW'(1'b1));
         check($sformatf("stall%0d_rsp_data", k), bus.rsp_data[0], bank_word(2'd1, 4'd1));
         check($sformatf("stall%0d_req_ready", k), DW'(bus.req_ready[0]), DW'(1'b0));
         next_cycle();
      end
      bus.rsp_ready = 2'b11;
      @(negedge clk);
      check("stall_accept_rsp_valid", DW'(bus.rsp_valid[0]), DW'(1'b1));
      check("stall_accept_rsp_data", bus.rsp_data[0], bank_word(2'd1, 4'd1));
      check("stall_accept_req_ready", DW'(bus.req_ready[0]), DW'(1'b0));
      next_cycle();
      @(negedge clk);
      check("stall_resume_req_ready", DW'(bus.req_ready[0]), DW'(1'b1));
      check("stall_resume_rsp_valid", DW'(bus.rsp_valid[0]), DW'(1'b0));
      next_cycle();
      bus.req_valid = '0;
      @(negedge clk);
      check("stall_second_rsp_valid", DW'(bus.rsp_valid[0]), DW'(1'b1));
      check("stall_second_rsp_data", bus.rsp_data[0], bank_word(2'd1, 4'd1));
      next_cycle();

      // Port 0 streams eight addresses back to back.
      do_reset();
      for (int k = 0; k < 9; k++) begin
         a = 6'(k);
         bus.req_valid   = (k < 8) ? 2'b01 : 2'b00;
         bus.req_addr[0] = a;
         @(negedge clk);
         if (k < 8) begin
            check($sformatf("str%0d_req_ready", k), DW'(bus.req_ready), DW'(2'b01));
            check($sformatf("str%0d_bank_en", k), DW'(bus.bank_rd_en), DW'(4'b0001 << bank_of(a)));
         end
         if (k > 0) begin
            ap = 6'(k - 1);
            check($sformatf("str%0d_rsp_valid", k), DW'(bus.rsp_valid), DW'(2'b01));
            check($sformatf("str%0d_rsp_data", k), bus.rsp_data[0], bank_word(bank_of(ap), row_of(ap)));
         end
         next_cycle();
      end

      // Reset right after a grant discards the response and rewinds rr_ptr.
      do_reset();
      bus.req_valid   = 2'b01;
      bus.req_addr[0] = 6'h05;
      bus.req_addr[1] = 6'h05;
      @(negedge clk);
      check("rstmid_grant", DW'(bus.req_ready), DW'(2'b01));
      next_cycle();
      rst = 1'b1;
      bus.req_valid = 2'b11;
      @(negedge clk);
      check("rstmid_rsp_valid", DW'(bus.rsp_valid), '0);
      check("rstmid_req_ready", DW'(bus.req_ready), '0);
      check("rstmid_bank_en", DW'(bus.bank_rd_en), '0);
      next_cycle();
      rst = 1'b0;
      bus.req_valid = '0;
      @(negedge clk);
      check("rstmid_after_rsp_valid", DW'(bus.rsp_valid), '0);
      next_cycle();
      bus.req_valid = 2'b11;
      @(negedge clk);
      check("rstmid_conflict_p0_wins", DW'(bus.req_ready), DW'(2'b01));
      next_cycle();
      bus.req_valid = '0;
      @(negedge clk);
      check("rstmid_conflict_rsp", DW'(bus.rsp_valid), DW'(2'b01));
      next_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
